chroma_subsample: RTL and testbench
===================================

Name: chroma_subsample

Overview:
- Encoder-side counterpart of the 4:2:0 chroma upsampler.
- Accepts 8x8 pixel blocks tagged Y/Cb/Cr.
- Y blocks pass straight through, registered.
- Each chroma 16x16 region arrives as four 8x8 quadrant blocks and is 2x2 box-averaged into one 8x8 chroma block.
- Per MCU: 12 blocks in (Y0..Y3, Cb q0..q3, Cr q0..q3), 6 blocks out (Y0..Y3, Cb, Cr).

Parameters:
- PIX_W, 9, pixel width (unsigned).
- CH, 3, number of channels; channel tag width is $clog2(CH+1).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- valid_in  in  1  input block valid, one block per cycle when high.
- ch_in  in  $clog2(CH+1)  0=Y, 1=Cb, 2=Cr; 3 is illegal.
- block_in  in  PIX_W x [7:0][7:0]  input block, [row][col].
- valid_out  out  1  output block valid, single-cycle pulse per block.
- ch_out  out  $clog2(CH+1)  channel of block_out.
- block_out  out  PIX_W x [7:0][7:0]  output block.
- quad_cnt  out  2  chroma quadrants accepted so far in current region.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst low, async): valid_out=0, ch_out=0, block_out all 0, quad_cnt=0, err=0, FSM=IDLE, accumulation buffer cleared.
- No backpressure. Every valid_in cycle is consumed. Back-to-back blocks are supported at full rate.
- Y path: valid_in with ch_in=0 gives, at the next posedge, valid_out=1, ch_out=0, block_out=block_in unmodified (latency 1).
  - Y does not disturb chroma accumulation state or quad_cnt.
- Chroma mapping, quadrant q: 0=TL, 1=TR, 2=BL, 3=BR.
  - For a,b in 0..3: buf[4*(q>>1)+a][4*(q&1)+b] = (p00+p01+p10+p11+2)>>2.
  - p00=in[2a][2b], p01=in[2a][2b+1], p10=in[2a+1][2b], p11=in[2a+1][2b+1].
  - Sum is 11 bits. Result is 9 bits and never overflows (max 511).
- FSM:
  - IDLE: chroma block arrives → write quadrant 0, latch acc_ch=ch_in, quad_cnt=1, go to ACC.
  - ACC, same channel, quad_cnt<3 → write quadrant quad_cnt, quad_cnt++.
  - ACC, same channel, quad_cnt==3 → write quadrant 3. Next cycle: valid_out=1, ch_out=acc_ch, block_out=completed buffer (latency 1 from 4th quadrant). quad_cnt=0, go to IDLE.
  - ACC, different chroma channel → err=1, discard partial region, treat block as quadrant 0 of the new channel (acc_ch=ch_in, quad_cnt=1).
- Simultaneous Y output and chroma completion cannot occur: one input per cycle means one output per cycle.
- ch_in=3 with valid_in → block dropped, err=1, state unchanged.
- valid_in=0 → no state change; valid_out=0 next cycle; block_out holds its last value.
- err is sticky until reset.
- Reset mid-accumulation discards the partial region and emits no output.

Decomposition:
- Shared package jpeg_pkg: PIX_W, CH, channel constants CH_Y=0, CH_CB=1, CH_CR=2, pixel/block typedefs. Shared with supersample_top.
- One combinational sub-module quad_avg: four PIX_W inputs → rounded PIX_W mean. Instantiate 16× via generate.
- FSM, quadrant counter, 64-entry buffer and output registers live in chroma_subsample.

Test Plan:
- Y ramp block (row 7 col 7 = 1 … row 0 col 0 = 64), ch_in=0 → next cycle valid_out=1, ch_out=0, block_out bit-identical. quad_cnt stays 0.
- Four Cb quadrants, constant 10, 20, 30, 40 (q0..q3), back-to-back → exactly one valid_out, one cycle after q3, ch_out=1. Rows 0-3/cols 0-3 = 10, cols 4-7 = 20; rows 4-7/cols 0-3 = 30, cols 4-7 = 40.
- Rounding check: 2x2 groups {1,2,2,2}→2, {0,0,0,1}→0, {1,1,1,0}→1, {511,511,511,511}→511, {0,0,0,2}→1.
- Full MCU, 12 blocks back-to-back (Y0..Y3, Cb×4, Cr×4) → valid_out pulses at input cycles 1-4 (Y), 8 (Cb), 12 (Cr). ch_out sequence 0,0,0,0,1,2. err=0.
- Cb q0, Cb q1, then Cr×4 → err=1, no Cb output, one Cr output one cycle after last Cr. Y block inserted between Cr q1 and Cr q2 passes through without breaking the Cr region.
- Cb q0, q1, assert rst for 2 cycles, then Cb×4 → single Cb output built only from post-reset blocks. err=0; quad_cnt=0 during reset.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG block-pipeline definitions used by the chroma subsampler and
// the matching supersampler.
//   PIX_W   - unsigned pixel width
//   CH      - number of colour channels (Y, Cb, Cr)
//   CH_W    - width of a channel tag, wide enough to also encode one illegal tag
//   CH_*    - channel tag values
//   pix_t / block_t - one pixel and one 8x8 block indexed [row][col]
//   ss_state_t - chroma accumulation FSM state
package jpeg_pkg;

  localparam int PIX_W = 9;
  localparam int CH    = 3;
  localparam int CH_W  = $clog2(CH + 1);

  localparam logic [CH_W-1:0] CH_Y  = CH_W'(0);
  localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
  localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [7:0][7:0]  block_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } ss_state_t;

endpackage

// File: rtl/quad_avg.sv
// Rounded mean of a 2x2 pixel group (purely combinational).
//   i_p00, i_p01, i_p10, i_p11 - the four pixels of the group
//   o_avg                      - (sum + 2) >> 2; cannot exceed the input range
module quad_avg #(
  parameter int PIX_W = 9
) (
  input  logic [PIX_W-1:0] i_p00,
  input  logic [PIX_W-1:0] i_p01,
  input  logic [PIX_W-1:0] i_p10,
  input  logic [PIX_W-1:0] i_p11,
  output logic [PIX_W-1:0] o_avg
);

  // Two extra bits hold the sum of four pixels plus the rounding bias.
  logic [PIX_W+1:0] w_sum;

  assign w_sum = {2'b00, i_p00} + {2'b00, i_p01} + {2'b00, i_p10} + {2'b00, i_p11}
               + (PIX_W + 2)'(2);
  assign o_avg = PIX_W'(w_sum >> 2);

endmodule

// File: rtl/chroma_subsample.sv
// 4:2:0 chroma subsampler for 8x8 blocks.
// Y blocks are registered straight through. Each chroma 16x16 region arrives
// as four 8x8 quadrant blocks (TL, TR, BL, BR); every quadrant is 2x2
// box-averaged into its 4x4 corner of an 8x8 buffer, and the buffer is emitted
// one cycle after the fourth quadrant.
//   clk, rst   - clock, asynchronous active-low reset
//   valid_in   - one block consumed per cycle while high (no backpressure)
//   ch_in      - channel tag: 0=Y, 1=Cb, 2=Cr, 3 illegal
//   block_in   - input block [row][col]
//   valid_out  - single-cycle pulse per output block
//   ch_out     - channel of block_out
//   block_out  - output block, holds its value between pulses
//   quad_cnt   - chroma quadrants accepted in the current region
//   err        - sticky protocol error (illegal tag or region interrupted)
// Handshake: valid-only. Every cycle with valid_in=1 transfers one block; the
// sink must accept every valid_out pulse.
module chroma_subsample #(
  parameter int PIX_W = jpeg_pkg::PIX_W,
  parameter int CH    = jpeg_pkg::CH,
  localparam int CHW  = $clog2(CH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic [CHW-1:0]                ch_in,
  input  logic [7:0][7:0][PIX_W-1:0]    block_in,
  output logic                          valid_out,
  output logic [CHW-1:0]                ch_out,
  output logic [7:0][7:0][PIX_W-1:0]    block_out,
  output logic [1:0]                    quad_cnt,
  output logic                          err
);

  import jpeg_pkg::*;

  localparam logic [CHW-1:0] L_Y  = CHW'(CH_Y);
  localparam logic [CHW-1:0] L_CB = CHW'(CH_CB);
  localparam logic [CHW-1:0] L_CR = CHW'(CH_CR);

  ss_state_t                  r_state, w_state_nxt;
  logic [1:0]                 r_quad_cnt;
  logic [CHW-1:0]             r_acc_ch;
  logic [7:0][7:0][PIX_W-1:0] r_buf;
  logic                       r_err;
  logic                       r_valid_out;
  logic [CHW-1:0]             r_ch_out;
  logic [7:0][7:0][PIX_W-1:0] r_block_out;

  logic                       w_is_y, w_is_c, w_is_bad;
  logic                       w_same, w_switch, w_done;
  logic [1:0]                 w_wr_q;
  logic [3:0][3:0][PIX_W-1:0] w_avg;
  logic [7:0][7:0][PIX_W-1:0] w_buf_nxt;
  logic                       w_valid_nxt;
  logic [CHW-1:0]             w_ch_nxt;
  logic [7:0][7:0][PIX_W-1:0] w_blk_nxt;

  // Input classification.
  assign w_is_y   = valid_in && (ch_in == L_Y);
  assign w_is_c   = valid_in && ((ch_in == L_CB) || (ch_in == L_CR));
  assign w_is_bad = valid_in && !w_is_y && !w_is_c;

  // A chroma block continues the open region only if its channel matches.
  assign w_same   = (r_state == ST_ACC) && (ch_in == r_acc_ch);
  assign w_switch = w_is_c && (r_state == ST_ACC) && !w_same;
  assign w_done   = w_is_c && w_same && (r_quad_cnt == 2'd3);
  // A new or restarted region always begins at quadrant 0.
  assign w_wr_q   = w_same ? r_quad_cnt : 2'd0;

  // 16 averagers, one per output position of a quadrant.
  for (genvar ga = 0; ga < 4; ga++) begin : g_row
    for (genvar gb = 0; gb < 4; gb++) begin : g_col
      quad_avg #(.PIX_W(PIX_W)) u_avg (
        .i_p00 (block_in[2*ga][2*gb]),
        .i_p01 (block_in[2*ga][2*gb+1]),
        .i_p10 (block_in[2*ga+1][2*gb]),
        .i_p11 (block_in[2*ga+1][2*gb+1]),
        .o_avg (w_avg[ga][gb])
      );
    end
  end

  // Buffer with the incoming quadrant merged in; also the source of the
  // completed block, so quadrant 3 appears in the output without a stall.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_is_c) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          w_buf_nxt[{w_wr_q[1], 2'b00} + 3'(a)][{w_wr_q[0], 2'b00} + 3'(b)] = w_avg[a][b];
        end
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM: next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_is_c) w_state_nxt = ST_ACC;
      ST_ACC:  if (w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: output selection. Only one block enters per cycle, so a Y
  // pass-through and a chroma completion never coincide.
  always_comb begin
    w_valid_nxt = w_is_y || w_done;
    w_ch_nxt    = w_is_y ? L_Y : r_acc_ch;
    w_blk_nxt   = w_is_y ? block_in : w_buf_nxt;
  end

  // Accumulation state and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quad_cnt  <= 2'd0;
      r_acc_ch    <= '0;
      r_buf       <= '0;
      r_err       <= 1'b0;
      r_valid_out <= 1'b0;
      r_ch_out    <= '0;
      r_block_out <= '0;
    end else begin
      if (w_is_c) begin
        r_buf <= w_buf_nxt;
        if (w_done)      r_quad_cnt <= 2'd0;
        else if (w_same) r_quad_cnt <= r_quad_cnt + 2'd1;
        else             r_quad_cnt <= 2'd1;
        if (!w_same)     r_acc_ch   <= ch_in;
      end
      if (w_is_bad || w_switch) r_err <= 1'b1;
      r_valid_out <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_ch_out    <= w_ch_nxt;
        r_block_out <= w_blk_nxt;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign ch_out    = r_ch_out;
  assign block_out = r_block_out;
  assign quad_cnt  = r_quad_cnt;
  assign err       = r_err;

endmodule

// File: tb/tb_chroma_subsample.sv
module tb_chroma_subsample;

  import jpeg_pkg::*;

  localparam int EW = 32 + 2 + 576;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic [1:0]   ch_in = '0;
  block_t       block_in = '0;
  logic         valid_out;
  logic [1:0]   ch_out;
  block_t       block_out;
  logic [1:0]   quad_cnt;
  logic         err;

  int unsigned  cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [EW-1:0] exp_q[$];
  block_t       last_blk = '0;

  chroma_subsample dut (
    .clk       (clk),
    .rst       (rst_n),
    .valid_in  (valid_in),
    .ch_in     (ch_in),
    .block_in  (block_in),
    .valid_out (valid_out),
    .ch_out    (ch_out),
    .block_out (block_out),
    .quad_cnt  (quad_cnt),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus helpers ----------------
  function automatic block_t const_blk(input int v);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 9'(v);
    return b;
  endfunction

  // row 7 col 7 = 1 ... row 0 col 0 = 64, plus offset
  function automatic block_t ramp_blk(input int off);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 9'(64 - (r * 8 + c) + off);
    return b;
  endfunction

  // Expected 8x8 chroma block from four constant quadrants TL, TR, BL, BR.
  function automatic block_t region_blk(input int v0, input int v1, input int v2, input int v3);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (r < 4) b[r][c] = (c < 4) ? 9'(v0) : 9'(v1);
        else       b[r][c] = (c < 4) ? 9'(v2) : 9'(v3);
      end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] ch, input block_t blk,
                       input bit expect_out, input logic [1:0] exp_ch, input block_t exp_blk);
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    ch_in    = ch;
    block_in = blk;
    if (expect_out) begin
      exp_q.push_back({32'(cyc + 1), exp_ch, exp_blk});
      last_blk = exp_blk;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    block_t        eb;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_output: no valid_out at cycle %0d (ch %0d expected)",
                 e[EW-1 -: 32], e[577:576]);
      end
      if (valid_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: valid_out at cycle %0d ch %0d, none expected", cyc, ch_out);
        end else begin
          e  = exp_q.pop_front();
          eb = e[575:0];
          if (e[EW-1 -: 32] != cyc || e[577:576] !== ch_out || eb !== block_out) begin
            errors++;
            $display("FAIL output_block: cycle %0d ch %0d got %h, expected cycle %0d ch %0d %h",
                     cyc, ch_out, block_out, e[EW-1 -: 32], e[577:576], eb);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    block_t rnd;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 32'(valid_out), 0);
    check("rst_ch_out", 32'(ch_out), 0);
    check("rst_block_out_zero", 32'(block_out != '0), 0);
    check("rst_quad_cnt", 32'(quad_cnt), 0);
    check("rst_err", 32'(err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Y ramp passes through with latency 1
    drive(2'd0, ramp_blk(0), 1'b1, 2'd0, ramp_blk(0));
    idle(2);
    @(negedge clk);
    check("y_quad_cnt", 32'(quad_cnt), 0);

    // Cb constant quadrants back-to-back
    drive(2'd1, const_blk(10), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(20), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(30), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(40), 1'b1, 2'd1, region_blk(10, 20, 30, 40));
    idle(2);
    @(negedge clk);
    check("cb_quad_cnt_after", 32'(quad_cnt), 0);

    // Rounding groups in TL quadrant (q0) and BR quadrant (q3) of a Cr region
    rnd = '0;
    rnd[0][0] = 9'd1;   rnd[0][1] = 9'd2;   rnd[1][0] = 9'd2;   rnd[1][1] = 9'd2;
    rnd[1][3] = 9'd1;
    rnd[0][4] = 9'd1;   rnd[0][5] = 9'd1;   rnd[1][4] = 9'd1;
    rnd[0][6] = 9'd511; rnd[0][7] = 9'd511; rnd[1][6] = 9'd511; rnd[1][7] = 9'd511;
    rnd[3][1] = 9'd2;
    begin
      block_t exp_r;
      exp_r = '0;
      exp_r[0][0] = 9'd2; exp_r[0][1] = 9'd0; exp_r[0][2] = 9'd1; exp_r[0][3] = 9'd511;
      exp_r[1][0] = 9'd1;
      exp_r[4][4] = 9'd2; exp_r[4][5] = 9'd0; exp_r[4][6] = 9'd1; exp_r[4][7] = 9'd511;
      exp_r[5][4] = 9'd1;
      drive(2'd2, rnd, 1'b0, 2'd0, '0);
      drive(2'd2, const_blk(0), 1'b0, 2'd0, '0);
      drive(2'd2, const_blk(0), 1'b0, 2'd0, '0);
      drive(2'd2, rnd, 1'b1, 2'd2, exp_r);
    end
    idle(2);
    @(negedge clk);
    check("round_err", 32'(err), 0);

    // Full MCU back-to-back
    for (int i = 0; i < 4; i++)
      drive(2'd0, ramp_blk(100 * i), 1'b1, 2'd0, ramp_blk(100 * i));
    drive(2'd1, const_blk(5), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(6), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(7), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(8), 1'b1, 2'd1, region_blk(5, 6, 7, 8));
    drive(2'd2, const_blk(50), 1'b0, 2'd0, '0);
    drive(2'd2, const_blk(60), 1'b0, 2'd0, '0);
    drive(2'd2, const_blk(70), 1'b0, 2'd0, '0);
    drive(2'd2, const_blk(80), 1'b1, 2'd2, region_blk(50, 60, 70, 80));
    idle(2);
    @(negedge clk);
    check("mcu_err", 32'(err), 0);
    check("mcu_quad_cnt", 32'(quad_cnt), 0);

    // Interrupted Cb region, Cr region with a Y block in the middle
    drive(2'd1, const_blk(11), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(12), 1'b0, 2'd0, '0);
    idle(1);
    @(negedge clk);
    check("partial_quad_cnt", 32'(quad_cnt), 2);
    drive(2'd2, const_blk(150), 1'b0, 2'd0, '0);
    drive(2'd2, const_blk(160), 1'b0, 2'd0, '0);
    drive(2'd0, ramp_blk(7), 1'b1, 2'd0, ramp_blk(7));
    drive(2'd2, const_blk(170), 1'b0, 2'd0, '0);
    drive(2'd2, const_blk(180), 1'b1, 2'd2, region_blk(150, 160, 170, 180));
    idle(2);
    @(negedge clk);
    check("switch_err", 32'(err), 1);
    check("switch_quad_cnt", 32'(quad_cnt), 0);

    // Reset mid-accumulation
    drive(2'd1, const_blk(99), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(99), 1'b0, 2'd0, '0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst_quad_cnt", 32'(quad_cnt), 0);
    check("midrst_valid_out", 32'(valid_out), 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_err", 32'(err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(2'd1, const_blk(21), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(22), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(23), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(24), 1'b1, 2'd1, region_blk(21, 22, 23, 24));
    idle(2);
    @(negedge clk);
    check("postrst_err", 32'(err), 0);

    // Illegal tag mid-region: dropped, err set, region continues
    drive(2'd1, const_blk(33), 1'b0, 2'd0, '0);
    drive(2'd3, const_blk(7), 1'b0, 2'd0, '0);
    idle(1);
    @(negedge clk);
    check("illegal_quad_cnt", 32'(quad_cnt), 1);
    check("illegal_err", 32'(err), 1);
    drive(2'd1, const_blk(44), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(55), 1'b0, 2'd0, '0);
    drive(2'd1, const_blk(66), 1'b1, 2'd1, region_blk(33, 44, 55, 66));
    idle(3);
    @(negedge clk);
    check("hold_valid_out", 32'(valid_out), 0);
    check("hold_block_out", 32'(block_out == last_blk), 1);
    check("hold_ch_out", 32'(ch_out), 1);

    idle(2);
    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
